// File: rtl/adc_frame_trigger_pkg.sv
// Shared types for the ADC frame trigger: FSM state encoding and the sample type.
package adc_frame_trigger_pkg;

    localparam int DATA_W_DEF = 12;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_TRIG = 2'b01,
        ST_CAPTURE   = 2'b10,
        ST_DONE      = 2'b11
    } state_e;

endpackage

// File: rtl/adc_frame_trigger_decimator.sv
// Decimator: free-running 0..decim counter; latches one ADC sample and strobes per wrap.
module adc_decimator
    import adc_frame_trigger_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DECIM_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [DATA_W-1:0]  i_adc_data,
    input  logic [DECIM_W-1:0] i_decim,
    output logic [DATA_W-1:0]  o_dec_sample,
    output logic               o_dec_stb
);

    logic [DECIM_W-1:0] r_dcnt;
    logic [DATA_W-1:0]  r_dec_sample;
    logic               r_dec_stb;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_dcnt       <= '0;
            r_dec_sample <= '0;
            r_dec_stb    <= 1'b0;
        end else begin
            r_dec_stb <= 1'b0;
            if (r_dcnt == i_decim) begin
                r_dcnt       <= '0;
                r_dec_sample <= i_adc_data;
                r_dec_stb    <= 1'b1;
            end else if (r_dcnt > i_decim) begin
                // ratio shrank under the counter: resync silently
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign o_dec_sample = r_dec_sample;
    assign o_dec_stb    = r_dec_stb;

endmodule

// File: rtl/adc_frame_trigger.sv
// Decimate ADC samples, wait for a hysteresis level trigger, emit one FRAME_LEN frame.
// Build option: define AUTO_TRIG_EN to force a trigger after TIMEOUT strobes in WAIT_TRIG.
module adc_frame_trigger
    import adc_frame_trigger_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DECIM_W   = 8,
    parameter int FRAME_LEN = 1024,
    parameter int HYST      = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [DATA_W-1:0]  i_adc_data,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic [DATA_W-1:0]  i_trig_level,
    input  logic               i_free_run,
    input  logic               i_arm,
    output logic [DATA_W-1:0]  o_data_out,
    output logic               o_data_valid,
    output logic               o_tongbu,
    output logic               o_busy,
    output logic [1:0]         o_state
);

    localparam int               FCNT_W = $clog2(FRAME_LEN);
    localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);

    state_e             r_state, w_state_nxt;
    logic [FCNT_W-1:0]  r_fcnt, w_fcnt_nxt;
    logic               r_low_seen, w_low_nxt;
    logic               w_emit, w_first, w_trig, w_below, w_auto;
    logic [DATA_W-1:0]  w_dec_sample, w_thr_low, r_cap, r_data_out;
    logic               w_dec_stb, r_emit, r_first, r_data_valid, r_tongbu;

    adc_decimator #(.DATA_W(DATA_W), .DECIM_W(DECIM_W)) u_dec (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_adc_data  (i_adc_data),
        .i_decim     (i_decim),
        .o_dec_sample(w_dec_sample),
        .o_dec_stb   (w_dec_stb)
    );

    assign w_thr_low = (i_trig_level > HYST_V) ? i_trig_level - HYST_V : '0;
    assign w_below   = w_dec_sample < w_thr_low;
    assign w_trig    = i_free_run | w_auto | (r_low_seen & (w_dec_sample >= i_trig_level));

`ifdef AUTO_TRIG_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] r_tcnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || r_state != ST_WAIT_TRIG) r_tcnt <= '0;
        else if (w_dec_stb)                        r_tcnt <= r_tcnt + 1'b1;
    end

    // the strobe that would bring the count to TIMEOUT fires the trigger
    assign w_auto = (r_tcnt == TCNT_W'(TIMEOUT - 1));
`else
    assign w_auto = (TIMEOUT < 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_low_nxt   = r_low_seen;
        w_emit      = 1'b0;
        w_first     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_low_nxt  = 1'b0;
                w_fcnt_nxt = '0;
                if (i_arm) w_state_nxt = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (!i_arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dec_stb) begin
                    if (w_trig) begin
                        w_state_nxt = ST_CAPTURE;
                        w_emit      = 1'b1;
                        w_first     = 1'b1;
                        w_fcnt_nxt  = FCNT_W'(1);
                        w_low_nxt   = 1'b0;
                    end else if (w_below) begin
                        w_low_nxt = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (w_dec_stb) begin
                    w_emit = 1'b1;
                    if (r_fcnt == FCNT_W'(FRAME_LEN - 1)) begin
                        w_state_nxt = ST_DONE;
                        w_fcnt_nxt  = '0;
                    end else begin
                        w_fcnt_nxt = r_fcnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_low_nxt   = 1'b0;
                w_state_nxt = i_arm ? ST_WAIT_TRIG : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // one capture stage plus one output stage: a latched sample reaches the pins two edges later
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_fcnt       <= '0;
            r_low_seen   <= 1'b0;
            r_emit       <= 1'b0;
            r_first      <= 1'b0;
            r_cap        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_tongbu     <= 1'b0;
        end else begin
            r_fcnt       <= w_fcnt_nxt;
            r_low_seen   <= w_low_nxt;
            r_emit       <= w_emit;
            r_first      <= w_first;
            if (w_emit) r_cap <= w_dec_sample;
            r_data_valid <= r_emit;
            r_tongbu     <= r_first;
            if (r_emit) r_data_out <= r_cap;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_tongbu     = r_tongbu;
    assign o_busy       = (r_state == ST_WAIT_TRIG) || (r_state == ST_CAPTURE);
    assign o_state      = r_state;

endmodule
